instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Inverse of the immediate decode path: packs instruction fields and a 64-bit signed immediate into 32-bit RV64 machine words.
- Streams each packed word into instruction memory at consecutive byte addresses.
- Used by the bench and boot path to load programs into the single-cycle CPU without an external assembler.
- Immediate conventions match the CPU decoder exactly, so decode(encode(x)) == x for every in-range x.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.
- MAX_WORDS, 256, number of words accepted before the block reports full.
- CNT_W, 9, width of count_o; must satisfy 2**CNT_W > MAX_WORDS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  pulse: reset write pointer, count and error flag; enter LOAD.
- valid_i  in  1  field bundle valid.
- ready_o  out  1  bundle accepted when valid_i && ready_o at a rising edge.
- fmt_i  in  2  0=I (0010011), 1=S (0100011), 2=B (1100011), 3=R (0110011).
- rd_i, rs1_i, rs2_i  in  5 each  register fields.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field; used for R only.
- imm_i  in  64  signed immediate in decoder units (B = byte offset / 2).
- we_o  out  1  instruction-memory write strobe.
- waddr_o  out  32  write byte address.
- wdata_o  out  32  encoded instruction.
- count_o  out  CNT_W  words written since start.
- full_o  out  1  count_o == MAX_WORDS.
- err_o  out  1  sticky: a bundle was rejected.

Behaviour:
- Reset (async, any state): state=IDLE; ready_o, we_o, full_o, err_o = 0; count_o = 0; waddr_o = BASE_ADDR; wdata_o = 0.
- All outputs are registered.

State machine (IDLE, LOAD, WRITE, FULL):
- IDLE: ready_o=0. On start_i go to LOAD.
- LOAD: ready_o=1.
  - On handshake with range check passing: latch the encoded word into wdata_o and go to WRITE.
  - On handshake with range check failing: set err_o, write nothing, do not advance the pointer, stay in LOAD.
- WRITE: we_o=1 for exactly one cycle at the current waddr_o; ready_o=0. Next edge: waddr_o += 4 and count_o += 1. Then go to FULL if the new count == MAX_WORDS, else LOAD.
- FULL: ready_o=0, full_o=1. Only start_i leaves this state.
- Throughput: one word per 2 cycles. Latency: handshake edge to we_o high is 1 cycle.

start_i handling:
- In LOAD or FULL: pointer = BASE_ADDR, count = 0, err_o = 0, full_o = 0; go to LOAD.
- In WRITE: the in-flight write completes unchanged, then the restart is applied instead of the increment.
- start_i and valid_i in the same LOAD cycle: start_i wins and the bundle is not accepted.

Range check:
- I, S, B: imm_i[63:11] must all equal imm_i[11] (range -2048..2047). R: always passes.

Encoding (common fields rs1 -> [19:15], funct3 -> [14:12], opcode -> [6:0]):
- I: [31:20]=imm[11:0], [11:7]=rd.
- S: [31:25]=imm[11:5], [24:20]=rs2, [11:7]=imm[4:0].
- B: [31]=imm[11], [30:25]=imm[9:4], [24:20]=rs2, [11:8]=imm[3:0], [7]=imm[10].
- R: [31:25]=funct7, [24:20]=rs2, [11:7]=rd.

Other rules:
- Inputs are ignored while ready_o=0.
- waddr_o wraps modulo 2^32 with no error.

Decomposition:
- Shared package:
  - FMT_I/S/B/R 2-bit encodings.
  - OPC_ITYPE=7'b0010011, OPC_STORE=7'b0100011, OPC_BRANCH=7'b1100011, OPC_RTYPE=7'b0110011.
  - State encodings.
  - The decoder should adopt the same opcode constants.
- Sub-module: instr_field_pack. Purely combinational (fields -> word, range_ok). It is reused by the bench as the reference model. The top level holds the FSM and counters.

Test Plan:
- I: start, then fmt=I, rd=1, rs1=0, funct3=0, imm=5 -> one cycle later we_o=1, waddr_o=0x0, wdata_o=0x00500093; then count_o=1.
- S: fmt=S, rs1=1, rs2=2, funct3=3, imm=-8 -> wdata_o=0xFE20BC23 at the next address (0x4). Feed the word to the decoder and check it returns -8 sign-extended.
- B: fmt=B, rs1=1, rs2=2, funct3=0, imm=-2 -> wdata_o=0xFE208EE3. Decoder returns 0xFFFF_FFFF_FFFF_FFFE.
- Range error: fmt=I, imm=2048 -> err_o=1, no we_o pulse, waddr_o and count_o unchanged, ready_o stays 1. Next valid bundle still writes. start_i clears err_o.
- Full: MAX_WORDS=4, stream 6 back-to-back valid bundles -> exactly 4 we_o pulses at 0x0/0x4/0x8/0xC, full_o=1, ready_o=0. start_i restarts at BASE_ADDR.
- Reset mid-operation: assert rst_i during WRITE -> we_o drops immediately (async), all outputs return to reset values, and the block ignores valid_i until start_i.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
// Shared constants for the instruction encoder/loader and the CPU decoder:
// field-bundle formats, base opcodes and loader FSM states.
package instr_encode_loader_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_R = 2'd3
  } fmt_e;

  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: instruction fields plus a signed 64-bit immediate
// (decoder units, B offsets already halved) -> 32-bit RV64 machine word.
module instr_field_pack
  import instr_encode_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  logic imm_fits_12;

  // Immediate fits 12 bits when every upper bit replicates the sign bit.
  assign imm_fits_12 = (imm[63:11] == {53{imm[11]}});

  // Place fields per format; R-type carries no immediate so it always passes.
  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned, which would otherwise infer latches.
    word     = '0;
    range_ok = imm_fits_12;
    unique case (fmt_e'(fmt))
      FMT_I: word = {imm[11:0], rs1, funct3, rd, OPC_ITYPE};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      FMT_B: word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10],
                     OPC_BRANCH};
      FMT_R: begin
        word     = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
        range_ok = 1'b1;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts field bundles, encodes them and streams the words
// into instruction memory at consecutive byte addresses, one word per two
// cycles, until MAX_WORDS have been written.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       fmt_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [63:0]      imm_i,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_e      state;
  logic [31:0] packed_word;
  logic        range_ok;
  logic        handshake;

  instr_field_pack u_pack (
    .fmt      (fmt_i),
    .rd       (rd_i),
    .rs1      (rs1_i),
    .rs2      (rs2_i),
    .funct3   (funct3_i),
    .funct7   (funct7_i),
    .imm      (imm_i),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  assign handshake = valid_i && ready_o;

  // Loader FSM with registered outputs; start_i restarts from any state and
  // takes priority over a simultaneous bundle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      ready_o <= 1'b0;
      we_o    <= 1'b0;
      waddr_o <= BASE_ADDR;
      wdata_o <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      err_o   <= 1'b0;
    end else if (start_i) begin
      // NOTE: sequential state uses non-blocking assignments so every branch
      // sees the pre-edge values of ready_o, count_o and waddr_o.
      // In WRITE the strobe already fired this cycle, so the restart simply
      // replaces the pointer/count increment.
      state   <= ST_LOAD;
      ready_o <= 1'b1;
      we_o    <= 1'b0;
      waddr_o <= BASE_ADDR;
      count_o <= '0;
      full_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ready_o <= 1'b0;
          we_o    <= 1'b0;
        end
        ST_LOAD: begin
          if (handshake) begin
            if (range_ok) begin
              wdata_o <= packed_word;
              we_o    <= 1'b1;
              ready_o <= 1'b0;
              state   <= ST_WRITE;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          we_o    <= 1'b0;
          waddr_o <= waddr_o + 32'd4;
          count_o <= count_o + 1'b1;
          if (count_o + 1'b1 == MAX_CNT) begin
            full_o  <= 1'b1;
            ready_o <= 1'b0;
            state   <= ST_FULL;
          end else begin
            ready_o <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_FULL: begin
          ready_o <= 1'b0;
          we_o    <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          ready_o <= 1'b0;
          we_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: table vectors, hand-written
// multi-cycle sequences and randomized bundles against a reference encoder.
module tb_instr_encode_loader;

  localparam int          MAXW = 4;
  localparam int          CW   = 3;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic          ready_o;
  logic [1:0]    fmt = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [63:0]   imm = '0;
  logic          we_o;
  logic [31:0]   waddr_o;
  logic [31:0]   wdata_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int idx     = 0;   // words written since the last start (model)
  bit err_model = 1'b0;

  instr_encode_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .CNT_W     (CW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .valid_i  (valid),
    .ready_o  (ready_o),
    .fmt_i    (fmt),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .imm_i    (imm),
    .we_o     (we_o),
    .waddr_o  (waddr_o),
    .wdata_o  (wdata_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [31:0] word;
    bit          ok;
  } vec_t;

  // Reference encoder built from the field tables with plain arithmetic.
  function automatic logic [31:0] ref_encode(input int f, input int r_d,
      input int r_s1, input int r_s2, input int f3, input int f7,
      input longint im, output bit ok);
    longint u, w;
    u  = im & 64'hFFF;
    ok = (f == 3) || (im >= -2048 && im <= 2047);
    w  = longint'(r_s1) * (1 << 15) + longint'(f3) * (1 << 12);
    case (f)
      0: w += u * (1 << 20) + r_d * 128 + 'h13;
      1: w += (u / 32) * (1 << 25) + r_s2 * (1 << 20) + (u % 32) * 128 + 'h23;
      2: w += ((u / 2048) % 2) * 64'h8000_0000 + ((u / 16) % 64) * (1 << 25)
            + r_s2 * (1 << 20) + (u % 16) * 256 + ((u / 1024) % 2) * 128 + 'h63;
      default: w += longint'(f7) * (1 << 25) + r_s2 * (1 << 20) + r_d * 128 + 'h33;
    endcase
    return w[31:0];
  endfunction

  // Reference decoder: immediate as the CPU sees it, sign-extended to 64 bits.
  function automatic logic [63:0] ref_decode(input logic [31:0] w);
    logic [11:0] i12;
    case (w[6:0])
      7'b0100011: i12 = {w[31:25], w[11:7]};
      7'b1100011: i12 = {w[31], w[7], w[30:25], w[11:8]};
      default:    i12 = w[31:20];
    endcase
    return {{52{i12[11]}}, i12};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    err_model = 1'b0;
  endtask

  // Present one bundle for a single cycle and check the write (or rejection).
  task automatic run_bundle(input vec_t v);
    if (full_o) do_start();
    check("ready before handshake", ready_o, 1);
    fmt = v.fmt; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    if (v.ok) begin
      check("we pulse", we_o, 1);
      check("waddr", waddr_o, BASE + 32'(4 * idx));
      check("wdata", wdata_o, v.word);
      if (v.fmt != 2'd3) check("decode roundtrip", ref_decode(wdata_o), v.imm);
      check("err sticky", err_o, err_model);
      tick();
      check("we one cycle", we_o, 0);
      check("count after write", count_o, idx + 1);
      idx++;
    end else begin
      err_model = 1'b1;
      check("reject no we", we_o, 0);
      check("reject err", err_o, 1);
      check("reject waddr", waddr_o, BASE + 32'(4 * idx));
      check("reject count", count_o, idx);
      check("reject ready", ready_o, 1);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int pulses;
    bit addr_ok;
    vec_t v;
    bit ok;

    vecs[0] = '{2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5,         32'h0050_0093, 1'b1};
    vecs[1] = '{2'd1, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, -64'sd8,       32'hFE20_BC23, 1'b1};
    vecs[2] = '{2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd2,       32'hFE20_8EE3, 1'b1};
    vecs[3] = '{2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048,      32'h0,         1'b0};
    vecs[4] = '{2'd3, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 64'h1234_5678_9ABC_DEF0, 32'h4052_01B3, 1'b1};
    vecs[5] = '{2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2047,      32'h7FF0_0013, 1'b1};
    vecs[6] = '{2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2048,    32'h8000_0013, 1'b1};
    vecs[7] = '{2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2049,    32'h0,         1'b0};
    vecs[8] = '{2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2047,      32'h7E00_0FE3, 1'b1};

    // Reset values
    #2;
    check("rst ready", ready_o, 0);
    check("rst we", we_o, 0);
    check("rst waddr", waddr_o, BASE);
    check("rst wdata", wdata_o, 0);
    check("rst count", count_o, 0);
    check("rst full", full_o, 0);
    check("rst err", err_o, 0);
    rst = 1'b0;
    tick();
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    check("idle ignores valid", we_o, 0);
    check("idle ready low", ready_o, 0);

    // Table vectors
    do_start();
    check("start clears count", count_o, 0);
    foreach (vecs[i]) run_bundle(vecs[i]);

    // Error clears on start, next valid bundle still writes
    do_start();
    run_bundle(vecs[3]);
    run_bundle(vecs[0]);
    do_start();
    check("start clears err", err_o, 0);

    // start_i and valid_i together in LOAD: start wins
    start = 1'b1; valid = 1'b1;
    tick();
    start = 1'b0; valid = 1'b0;
    check("start+valid no we", we_o, 0);
    check("start+valid count", count_o, 0);
    check("start+valid ready", ready_o, 1);

    // Back-to-back valid until full
    fmt = 2'd0; rd = 5'd2; rs1 = 5'd0; funct3 = 3'd0; imm = 64'd1;
    valid = 1'b1;
    pulses = 0;
    addr_ok = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (we_o) begin
        if (waddr_o !== BASE + 32'(4 * pulses)) addr_ok = 1'b0;
        pulses++;
      end
    end
    valid = 1'b0;
    check("full pulses", pulses, MAXW);
    check("full addresses", addr_ok, 1);
    check("full flag", full_o, 1);
    check("full ready", ready_o, 0);
    check("full count", count_o, MAXW);
    do_start();
    check("restart waddr", waddr_o, BASE);
    check("restart full", full_o, 0);
    check("restart ready", ready_o, 1);

    // start_i during WRITE: write completes, restart replaces increment
    run_bundle(vecs[0]);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("inflight we", we_o, 1);
    check("inflight waddr", waddr_o, BASE + 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    check("write-start we", we_o, 0);
    check("write-start waddr", waddr_o, BASE);
    check("write-start count", count_o, 0);
    check("write-start ready", ready_o, 1);

    // Async reset during WRITE
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("pre-reset we", we_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst we", we_o, 0);
    check("async rst waddr", waddr_o, BASE);
    check("async rst wdata", wdata_o, 0);
    check("async rst count", count_o, 0);
    check("async rst ready", ready_o, 0);
    rst = 1'b0;
    valid = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (we_o || ready_o) pulses++;
    end
    valid = 1'b0;
    check("post-reset ignores valid", pulses, 0);
    do_start();
    run_bundle(vecs[1]);

    // Randomized bundles against the reference encoder
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) do_start();
      v.fmt = 2'($urandom_range(3));
      v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
      v.f3  = 3'($urandom); v.f7  = 7'($urandom);
      if ($urandom_range(3) == 0) v.imm = {$urandom, $urandom};
      else v.imm = 64'(longint'($urandom_range(4095)) - 2048);
      v.word = ref_encode(int'(v.fmt), int'(v.rd), int'(v.rs1), int'(v.rs2),
                          int'(v.f3), int'(v.f7), longint'(v.imm), ok);
      v.ok = ok;
      run_bundle(v);
      for (int g = $urandom_range(2); g > 0; g--) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
